// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: drives IM address/enable and the PC/valid/prediction sideband
// aligned with IM's registered Instruction. Optional BTB predictor enabled by FETCH_BTB_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] IMaddr,
    output logic        IMen,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0] pc_q;
    logic        pred_taken;
    logic [31:0] pred_target;

    // During a stall IM re-reads the held instruction so its output stays stable.
    assign IMaddr = (stall ? if_pc : pc_q) & ALIGN_MASK;
    assign IMen   = !rst && !redirect_valid;

`ifdef FETCH_BTB_EN
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [31:0]            btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       unused_bits;

    assign lk_idx = pc_q[2 +: IDX_W];
    assign lk_tag = pc_q[31:2+IDX_W];
    assign up_idx = upd_pc[2 +: IDX_W];
    assign up_tag = upd_pc[31:2+IDX_W];
    assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
    assign unused_bits = upd_pc[1:0];

    // Lookup sees pre-edge contents; same-cycle updates are deliberately not bypassed.
    assign pred_taken  = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag) && btb_ctr[lk_idx][1];
    assign pred_target = pred_taken ? btb_target[lk_idx] : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (upd_valid && !up_hit && upd_taken) begin
            btb_valid[up_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    btb_target[up_idx] <= upd_target & ALIGN_MASK;
                    if (btb_ctr[up_idx] != 2'b11) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
                end else if (btb_ctr[up_idx] != 2'b00) begin
                    btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                btb_tag[up_idx]    <= up_tag;
                btb_target[up_idx] <= upd_target & ALIGN_MASK;
                btb_ctr[up_idx]    <= 2'b10;
            end
        end
    end
`else
    logic unused_upd;

    assign unused_upd  = ^{upd_valid, upd_pc, upd_taken, upd_target};
    assign pred_taken  = 1'b0;
    assign pred_target = 32'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= RESET_PC & ALIGN_MASK;
            if_pc          <= 32'd0;
            if_valid       <= 1'b0;
            if_pred_taken  <= 1'b0;
            if_pred_target <= 32'd0;
        end else if (redirect_valid) begin
            pc_q           <= redirect_pc & ALIGN_MASK;
            if_valid       <= 1'b0;
            if_pred_taken  <= 1'b0;
            if_pred_target <= 32'd0;
        end else if (!stall) begin
            if_pc          <= pc_q;
            if_valid       <= 1'b1;
            if_pred_taken  <= pred_taken;
            if_pred_target <= pred_target;
            pc_q           <= pred_taken ? pred_target : pc_q + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; covers both the default build and FETCH_BTB_EN.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] IMaddr;
    logic        IMen;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;

    int n_cmp = 0;
    int n_err = 0;

    fetch_pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .IMaddr(IMaddr), .IMen(IMen), .if_pc(if_pc), .if_valid(if_valid),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;

        // 1: reset, then sequential fetch
        repeat (3) @(posedge clk);
        #2;
        chk("rst_imen", 32'(IMen), 0);
        chk("rst_valid", 32'(if_valid), 0);
        chk("rst_pred", 32'(if_pred_taken), 0);
        rst = 1'b0;
        #1;
        chk("rel_addr", IMaddr, 32'h0);
        chk("rel_imen", 32'(IMen), 1);
        chk("rel_valid", 32'(if_valid), 0);
        tick(); #1;
        chk("seq1_addr", IMaddr, 32'h4);
        chk("seq1_pc", if_pc, 32'h0);
        chk("seq1_valid", 32'(if_valid), 1);
        tick(); #1;
        chk("seq2_addr", IMaddr, 32'h8);
        chk("seq2_pc", if_pc, 32'h4);
        tick(); #1;
        chk("seq3_addr", IMaddr, 32'hC);
        chk("seq3_pc", if_pc, 32'h8);

        // 2: stall two cycles while if_pc=8
        stall = 1'b1; #1;
        chk("stall0_addr", IMaddr, 32'h8);
        chk("stall0_imen", 32'(IMen), 1);
        tick(); #1;
        chk("stall1_addr", IMaddr, 32'h8);
        chk("stall1_pc", if_pc, 32'h8);
        tick();
        stall = 1'b0; #1;
        chk("stall2_pc", if_pc, 32'h8);
        chk("unstall_addr", IMaddr, 32'hC);
        tick(); #1;
        chk("resume_pc", if_pc, 32'hC);
        chk("resume_addr", IMaddr, 32'h10);

        // 3: redirect to 0x78 while if_pc=4
        redirect_valid = 1'b1; redirect_pc = 32'h4;
        tick();
        redirect_valid = 1'b0;
        tick(); #1;
        chk("pre3_pc", if_pc, 32'h4);
        redirect_valid = 1'b1; redirect_pc = 32'h78; #1;
        chk("redir_imen", 32'(IMen), 0);
        tick();
        redirect_valid = 1'b0; #1;
        chk("redir_bubble", 32'(if_valid), 0);
        chk("redir_addr", IMaddr, 32'h78);
        tick(); #1;
        chk("redir_pc", if_pc, 32'h78);
        chk("redir_valid", 32'(if_valid), 1);
        chk("redir_next", IMaddr, 32'h7C);

        // 4: redirect beats stall; unaligned target is forced to word alignment
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h203; #1;
        chk("rs_imen", 32'(IMen), 0);
        tick();
        stall = 1'b0; redirect_valid = 1'b0; #1;
        chk("rs_addr", IMaddr, 32'h200);
        chk("rs_valid", 32'(if_valid), 0);
        tick(); #1;
        chk("rs_pc", if_pc, 32'h200);

        // modulo wrap at top of address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick(); #1;
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", IMaddr, 32'h0);

        // 5: train taken 0x10 -> 0x40, then fetch 0x10
        upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h40;
        tick();
        upd_valid = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        tick(); #1;
        chk("btb_pc", if_pc, 32'h10);
`ifdef FETCH_BTB_EN
        chk("btb_taken", 32'(if_pred_taken), 1);
        chk("btb_target", if_pred_target, 32'h40);
        chk("btb_addr", IMaddr, 32'h40);
        tick(); #1;
        chk("btb_tgt_pc", if_pc, 32'h40);
        chk("btb_tgt_pred", 32'(if_pred_taken), 0);
`else
        chk("nobtb_taken", 32'(if_pred_taken), 0);
        chk("nobtb_target", if_pred_target, 32'h0);
        chk("nobtb_addr", IMaddr, 32'h14);
`endif
        // two not-taken updates turn prediction off
        upd_valid = 1'b1; upd_taken = 1'b0;
        tick();
        tick();
        upd_valid = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        tick(); #1;
        chk("nt_pc", if_pc, 32'h10);
        chk("nt_pred", 32'(if_pred_taken), 0);
        chk("nt_addr", IMaddr, 32'h14);

        // 6: retrain to taken, then async reset mid-cycle
        upd_valid = 1'b1; upd_taken = 1'b1;
        tick();
        tick();
        upd_valid = 1'b0;
        tick(); #1;
        chk("pre_rst_valid", 32'(if_valid), 1);
        rst = 1'b1; #1;
        chk("arst_imen", 32'(IMen), 0);
        chk("arst_valid", 32'(if_valid), 0);
        tick();
        rst = 1'b0; #1;
        chk("arst_addr", IMaddr, 32'h0);
        chk("arst_imen_rel", 32'(IMen), 1);
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        tick(); #1;
        chk("arst_btb_pc", if_pc, 32'h10);
        chk("arst_btb_pred", 32'(if_pred_taken), 0);
        chk("arst_btb_addr", IMaddr, 32'h14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
